// File: rtl/k_sym_pkg.sv
// Shared types and 8b/10b control-code constants for the K-symbol scheduler.
package k_sym_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_ALIGN,
      ST_IDLE,
      ST_SKP,
      ST_SOF,
      ST_DATA,
      ST_EOF
   } state_t;

   localparam logic [7:0] K28_0 = 8'h1C;  // SKP
   localparam logic [7:0] K28_3 = 8'h7C;  // SOF
   localparam logic [7:0] K28_4 = 8'h9C;  // EOF
   localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
   localparam logic [7:0] K28_7 = 8'hFC;  // FILL

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/k_skp_timer.sv
// Clock-compensation timer: counts link-up symbols and raises a sticky SKP request
// every SKP_INTERVAL symbols until the scheduler serves it.
module k_skp_timer #(
   parameter int SKP_INTERVAL = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count,
   input  logic clear,
   input  logic served,
   output logic pending
);

   localparam int CW = $clog2(SKP_INTERVAL);

   logic [CW-1:0] skp_cnt;
   logic          wrap;

   assign wrap = count && (skp_cnt == CW'(SKP_INTERVAL - 1));

   // NOTE: reset is synchronous here, so it sits inside the clocked branch rather than
   // in the sensitivity list; all state uses non-blocking assignment.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         skp_cnt <= '0;
         pending <= 1'b0;
      end else begin
         if (wrap)
            skp_cnt <= '0;
         else if (count)
            skp_cnt <= skp_cnt + CW'(1);

         // A wrap while already pending simply keeps the request; requests never queue.
         if (wrap)
            pending <= 1'b1;
         else if (served)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/k_symbol_scheduler.sv
// Picks the next symbol each cycle (frame byte or control code), drives the encoder
// strobes and owns the shared running-disparity register.
module k_symbol_scheduler
   import k_sym_pkg::*;
#(
   parameter int ALIGN_LEN    = 16,
   parameter int SKP_INTERVAL = 1024,
   parameter int SKP_LEN      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic       force_align,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] sym_data,
   output logic       sym_k,
   output logic       sym_k_r,
   output logic       sym_dv,
   input  logic       enc_rd_in,
   input  logic       enc_rd_vld,
   output logic       rd_out,
   output logic       link_up
);

   localparam int BW = $clog2(max2(ALIGN_LEN, SKP_LEN) + 1);

   state_t        state_q, state_d;
   logic [BW-1:0] burst_cnt;
   logic          align_req;
   logic          skp_pending;
   logic          rd_q;
   logic [7:0]    sym_data_d;
   logic          sym_k_d;
   logic          sym_dv_d;

   assign s_ready = (state_q == ST_DATA);
   assign link_up = (state_q == ST_IDLE) || (state_q == ST_SOF) || (state_q == ST_DATA) ||
                    (state_q == ST_EOF)  || (state_q == ST_SKP);
   assign rd_out  = enc_rd_vld ? enc_rd_in : rd_q;

   k_skp_timer #(
      .SKP_INTERVAL(SKP_INTERVAL)
   ) u_skp_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .count  (link_up),
      .clear  (state_q == ST_ALIGN),
      .served (state_q == ST_SKP),
      .pending(skp_pending)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      sym_data_d = '0;
      sym_k_d    = 1'b0;
      sym_dv_d   = 1'b0;
      unique case (state_q)
         ST_OFF: begin
            if (tx_en) state_d = ST_ALIGN;
         end
         ST_ALIGN: begin
            sym_data_d = K28_5;
            sym_k_d    = 1'b1;
            if (burst_cnt == BW'(ALIGN_LEN - 1)) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            sym_data_d = K28_5;
            sym_k_d    = 1'b1;
            if (align_req)        state_d = ST_ALIGN;
            else if (skp_pending) state_d = ST_SKP;
            else if (s_valid)     state_d = ST_SOF;
         end
         ST_SKP: begin
            sym_data_d = K28_0;
            sym_k_d    = 1'b1;
            if (burst_cnt == BW'(SKP_LEN - 1)) state_d = ST_IDLE;
         end
         ST_SOF: begin
            sym_data_d = K28_3;
            sym_k_d    = 1'b1;
            state_d    = ST_DATA;
         end
         ST_DATA: begin
            if (s_valid) begin
               sym_data_d = s_data;
               sym_dv_d   = 1'b1;
               if (s_last) state_d = ST_EOF;
            end else begin
               // Underrun: pad with FILL and keep the frame open.
               sym_data_d = K28_7;
               sym_k_d    = 1'b1;
            end
         end
         ST_EOF: begin
            sym_data_d = K28_4;
            sym_k_d    = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_OFF;
      endcase
      if (!tx_en) state_d = ST_OFF;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_OFF;
         burst_cnt <= '0;
         align_req <= 1'b0;
         rd_q      <= 1'b0;
         sym_data  <= '0;
         sym_k     <= 1'b0;
         sym_k_r   <= 1'b0;
         sym_dv    <= 1'b0;
      end else begin
         state_q <= state_d;

         // Burst length restarts on every state change and only advances in ALIGN/SKP.
         if (state_d != state_q)
            burst_cnt <= '0;
         else if (state_q == ST_ALIGN || state_q == ST_SKP)
            burst_cnt <= burst_cnt + BW'(1);

         if (force_align)
            align_req <= 1'b1;
         else if (state_q == ST_ALIGN)
            align_req <= 1'b0;

         rd_q     <= rd_out;
         sym_data <= sym_data_d;
         sym_k    <= sym_k_d;
         sym_k_r  <= sym_k;
         sym_dv   <= sym_dv_d;
      end
   end

endmodule

// File: tb/tb_k_symbol_scheduler.sv
// Directed bench for k_symbol_scheduler: bring-up, framing, underrun, SKP timing,
// forced re-alignment, running disparity, link drop and reset.
module tb_k_symbol_scheduler;

   localparam logic [9:0] S_OFF = 10'h000;
   localparam logic [9:0] S_BC  = {2'b10, 8'hBC};
   localparam logic [9:0] S_1C  = {2'b10, 8'h1C};
   localparam logic [9:0] S_7C  = {2'b10, 8'h7C};
   localparam logic [9:0] S_9C  = {2'b10, 8'h9C};
   localparam logic [9:0] S_FC  = {2'b10, 8'hFC};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_en = 1'b0;
   logic       force_align = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [7:0] sym_data;
   logic       sym_k;
   logic       sym_k_r;
   logic       sym_dv;
   logic       enc_rd_in = 1'b0;
   logic       enc_rd_vld = 1'b0;
   logic       rd_out;
   logic       link_up;

   int errors = 0;
   int checks = 0;
   int hs_cnt = 0;

   // Captured stream: {sym_k_r, sym_k, sym_dv, sym_data} and link_up, one entry per cycle.
   logic [10:0] syms[$];
   logic        lus[$];
   bit          cap = 1'b0;

   always #5 clk = ~clk;

   k_symbol_scheduler #(
      .ALIGN_LEN   (16),
      .SKP_INTERVAL(32),
      .SKP_LEN     (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_en      (tx_en),
      .force_align(force_align),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .sym_data   (sym_data),
      .sym_k      (sym_k),
      .sym_k_r    (sym_k_r),
      .sym_dv     (sym_dv),
      .enc_rd_in  (enc_rd_in),
      .enc_rd_vld (enc_rd_vld),
      .rd_out     (rd_out),
      .link_up    (link_up)
   );

   always @(posedge clk) begin
      #1;
      if (cap) begin
         syms.push_back({sym_k_r, sym_k, sym_dv, sym_data});
         lus.push_back(link_up);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] sym_at(input int i);
      if (i < 0 || i >= syms.size()) return 10'h3FF;
      return syms[i][9:0];
   endfunction

   function automatic int find_sym(input logic [9:0] v, input int from);
      for (int i = from; i < syms.size(); i++)
         if (syms[i][9:0] == v) return i;
      return -1;
   endfunction

   task automatic restart_capture();
      syms.delete();
      lus.delete();
      cap = 1'b1;
   endtask

   // Sends up to 4 bytes; gap[i] idle cycles precede byte i. Inputs change on negedge.
   task automatic send_frame(input logic [7:0] d[4], input int gap[4], input int n);
      int waited;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b0;
         s_last  = 1'b0;
         repeat (gap[i]) @(negedge clk);
         s_valid = 1'b1;
         s_data  = d[i];
         s_last  = (i == n - 1);
         waited  = 0;
         while (!s_ready && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         if (!s_ready) begin
            check("frame_ready_timeout", 32'(s_ready), 32'd1);
            break;
         end
         hs_cnt++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, e, bad, first_lu;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sym_data", 32'(sym_data), 32'h0);
      check("rst_sym_k", 32'(sym_k), 32'h0);
      check("rst_sym_k_r", 32'(sym_k_r), 32'h0);
      check("rst_sym_dv", 32'(sym_dv), 32'h0);
      check("rst_link_up", 32'(link_up), 32'h0);
      check("rst_s_ready", 32'(s_ready), 32'h0);
      check("rst_rd_out", 32'(rd_out), 32'h0);

      // Bring-up: one OFF symbol, then K28.5; link_up after 16 ALIGN cycles; SKP at 50/51, 82/83
      restart_capture();
      rst_n = 1'b1;
      tx_en = 1'b1;
      repeat (86) @(negedge clk);
      check("bringup_off_sym", 32'(sym_at(0)), 32'(S_OFF));
      bad = 0;
      for (int i = 1; i <= 49; i++) if (sym_at(i) != S_BC) bad++;
      check("bringup_bc_run", 32'(bad), 32'd0);
      first_lu = -1;
      for (int i = 0; i < lus.size(); i++)
         if (lus[i] && first_lu < 0) first_lu = i;
      check("bringup_link_up_idx", 32'(first_lu), 32'd16);
      check("bringup_k_r_first", 32'(syms[1][10]), 32'd0);
      check("bringup_k_r_second", 32'(syms[2][10]), 32'd1);
      check("skp1_a", 32'(sym_at(50)), 32'(S_1C));
      check("skp1_b", 32'(sym_at(51)), 32'(S_1C));
      check("skp1_after", 32'(sym_at(52)), 32'(S_BC));
      check("skp2_before", 32'(sym_at(81)), 32'(S_BC));
      check("skp2_a", 32'(sym_at(82)), 32'(S_1C));
      check("skp2_b", 32'(sym_at(83)), 32'(S_1C));

      // Plain frame 11,22,33
      restart_capture();
      hs_cnt = 0;
      send_frame('{8'h11, 8'h22, 8'h33, 8'h00}, '{0, 0, 0, 0}, 3);
      repeat (3) @(negedge clk);
      p = find_sym(S_7C, 0);
      check("f1_sof", 32'(sym_at(p)), 32'(S_7C));
      check("f1_b0", 32'(sym_at(p + 1)), 32'({2'b01, 8'h11}));
      check("f1_b1", 32'(sym_at(p + 2)), 32'({2'b01, 8'h22}));
      check("f1_b2", 32'(sym_at(p + 3)), 32'({2'b01, 8'h33}));
      check("f1_eof", 32'(sym_at(p + 4)), 32'(S_9C));
      check("f1_idle", 32'(sym_at(p + 5)), 32'(S_BC));
      check("f1_handshakes", 32'(hs_cnt), 32'd3);

      // Underrun of two cycles after the first byte
      restart_capture();
      hs_cnt = 0;
      send_frame('{8'h44, 8'h55, 8'h66, 8'h00}, '{0, 2, 0, 0}, 3);
      repeat (3) @(negedge clk);
      p = find_sym(S_7C, 0);
      check("f2_sof", 32'(sym_at(p)), 32'(S_7C));
      check("f2_b0", 32'(sym_at(p + 1)), 32'({2'b01, 8'h44}));
      check("f2_fill0", 32'(sym_at(p + 2)), 32'(S_FC));
      check("f2_fill1", 32'(sym_at(p + 3)), 32'(S_FC));
      check("f2_b1", 32'(sym_at(p + 4)), 32'({2'b01, 8'h55}));
      check("f2_b2", 32'(sym_at(p + 5)), 32'({2'b01, 8'h66}));
      check("f2_eof", 32'(sym_at(p + 6)), 32'(S_9C));
      check("f2_handshakes", 32'(hs_cnt), 32'd3);

      // Frame spanning a SKP wrap, next frame queued behind it: SKP precedes the next SOF
      restart_capture();
      send_frame('{8'hA1, 8'hA2, 8'h00, 8'h00}, '{0, 40, 0, 0}, 2);
      send_frame('{8'hB1, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0}, 1);
      repeat (4) @(negedge clk);
      p = find_sym(S_7C, 0);
      e = find_sym(S_9C, 0);
      bad = 0;
      for (int i = p + 1; i < e; i++) if (sym_at(i) == S_FC) bad++;
      check("f3_fill_count", 32'(bad), 32'd40);
      check("f3_eof_idle", 32'(sym_at(e + 1)), 32'(S_BC));
      check("f3_skp_a", 32'(sym_at(e + 2)), 32'(S_1C));
      check("f3_skp_b", 32'(sym_at(e + 3)), 32'(S_1C));
      check("f3_idle", 32'(sym_at(e + 4)), 32'(S_BC));
      check("f3_next_sof", 32'(sym_at(e + 5)), 32'(S_7C));

      // force_align mid-frame plus a pending SKP: ALIGN wins and resets the SKP interval
      restart_capture();
      fork
         send_frame('{8'hC1, 8'hC2, 8'h00, 8'h00}, '{0, 40, 0, 0}, 2);
         begin
            repeat (10) @(negedge clk);
            force_align = 1'b1;
            @(negedge clk);
            force_align = 1'b0;
         end
      join
      repeat (60) @(negedge clk);
      e = find_sym(S_9C, 0);
      bad = 0;
      for (int i = e + 1; i <= e + 17; i++) if (sym_at(i) != S_BC) bad++;
      check("fa_bc_run", 32'(bad), 32'd0);
      check("fa_link_down", 32'(lus[e + 3]), 32'd0);
      check("fa_next_skp_idx", 32'(find_sym(S_1C, e) - e), 32'd51);
      cap = 1'b0;

      // Running disparity bypass and hold
      enc_rd_vld = 1'b1;
      enc_rd_in  = 1'b1;
      #1 check("rd_bypass_1", 32'(rd_out), 32'd1);
      @(negedge clk);
      enc_rd_vld = 1'b0;
      enc_rd_in  = 1'b0;
      #1 check("rd_hold_1", 32'(rd_out), 32'd1);
      @(negedge clk);
      check("rd_hold_1_later", 32'(rd_out), 32'd1);
      enc_rd_vld = 1'b1;
      #1 check("rd_bypass_0", 32'(rd_out), 32'd0);
      @(negedge clk);
      enc_rd_vld = 1'b0;
      enc_rd_in  = 1'b1;
      #1 check("rd_hold_0", 32'(rd_out), 32'd0);
      @(negedge clk);
      enc_rd_vld = 1'b1;
      @(negedge clk);
      enc_rd_vld = 1'b0;

      // Link drop mid-frame
      s_valid = 1'b1;
      s_data  = 8'hAA;
      s_last  = 1'b0;
      for (int i = 0; i < 40 && !s_ready; i++) @(negedge clk);
      check("drop_in_data", 32'(s_ready), 32'd1);
      tx_en = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      check("drop_s_ready", 32'(s_ready), 32'd0);
      check("drop_link_up", 32'(link_up), 32'd0);
      check("drop_last_byte", 32'({sym_k, sym_dv, sym_data}), 32'({2'b01, 8'hAA}));
      @(negedge clk);
      check("drop_off_sym", 32'({sym_k, sym_dv, sym_data}), 32'h0);

      // Re-enable, then synchronous reset while the link is up
      tx_en = 1'b1;
      repeat (25) @(negedge clk);
      check("reup_link_up", 32'(link_up), 32'd1);
      check("pre_rst_rd", 32'(rd_out), 32'd1);
      s_valid = 1'b1;
      rst_n   = 1'b0;
      @(negedge clk);
      check("rst2_sym_data", 32'(sym_data), 32'h0);
      check("rst2_sym_k", 32'(sym_k), 32'h0);
      check("rst2_sym_k_r", 32'(sym_k_r), 32'h0);
      check("rst2_sym_dv", 32'(sym_dv), 32'h0);
      check("rst2_link_up", 32'(link_up), 32'h0);
      check("rst2_s_ready", 32'(s_ready), 32'h0);
      check("rst2_rd_out", 32'(rd_out), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
